// File: rtl/uart_receiver_if.sv
// Byte-side and line-side signals of the UART receiver.
// master is the receiver side; slave is the line driver / byte consumer side.
interface uart_receiver_if;
  logic       rcv;
  logic       ack;
  logic [7:0] data;
  logic       req;
  logic       err;
  logic       ovr;

  modport master (input rcv, ack, output data, req, err, ovr);
  modport slave  (output rcv, ack, input data, req, err, ovr);
endinterface

// File: rtl/uart_receiver.sv
// UART receiver: 2-flop sync, tick divider, frame FSM and a four-phase req/ack delivery FSM.
// Optional UART_RCV_GLITCH_FILTER_EN: 2-of-3 majority sampling around SAMPLE_TICK.
module uart_receiver #(
  parameter int DIVIDE        = 2,
  parameter int TICKS_PER_BIT = 9,
  parameter int SAMPLE_TICK   = 4
) (
  input  logic            clk,
  input  logic            clr,
  uart_receiver_if.master u
);
  localparam int DW  = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;
  localparam int TCW = $clog2(TICKS_PER_BIT);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_st_t;
  typedef enum logic [1:0] {H_IDLE, H_REQ, H_DROP} hs_st_t;

  rx_st_t         st, st_nx;
  hs_st_t         hs, hs_nx;
  logic           s1, rs;
  logic [DW-1:0]  div;
  logic [TCW-1:0] tc;
  logic [2:0]     idx, pos;
  logic [7:0]     sh, data_q;
  logic           run, tick, last, dec, bitv;
  logic           good, ferr, load, ovr_set;
  logic           err_q, ovr_q;

  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      s1 <= 1'b1;
      rs <= 1'b1;
    end else begin
      s1 <= u.rcv;
      rs <= s1;
    end

  // Divider and tick counter only run while a frame is in flight; IDLE pins them to 0.
  assign run  = st inside {START, DATA, STOP};
  assign tick = run && (div == DW'(DIVIDE - 1));
  assign last = tick && (tc == TCW'(TICKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      div <= '0;
      tc  <= '0;
    end else if (!run) begin
      div <= '0;
      tc  <= '0;
    end else begin
      div <= tick ? '0 : div + DW'(1);
      if (tick) tc <= last ? '0 : tc + TCW'(1);
    end

`ifdef UART_RCV_GLITCH_FILTER_EN
  logic m0, m1;
  assign dec  = tick && (tc == TCW'(SAMPLE_TICK + 1));
  assign bitv = (m0 & m1) | (m0 & rs) | (m1 & rs);

  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      m0 <= 1'b1;
      m1 <= 1'b1;
    end else begin
      if (tick && tc == TCW'(SAMPLE_TICK - 1)) m0 <= rs;
      if (tick && tc == TCW'(SAMPLE_TICK))     m1 <= rs;
    end
`else
  assign dec  = tick && (tc == TCW'(SAMPLE_TICK));
  assign bitv = rs;
`endif

  always_comb begin
    st_nx = st;
    good  = 1'b0;
    ferr  = 1'b0;
    case (st)
      IDLE:      if (!rs) st_nx = START;
      START:     if (dec && bitv) st_nx = IDLE;
                 else if (last)   st_nx = DATA;
      DATA:      if (last && idx == 3'd7) st_nx = STOP;
      STOP:      if (dec) begin
                   if (bitv) begin
                     good  = 1'b1;
                     st_nx = IDLE;
                   end else begin
                     ferr  = 1'b1;
                     st_nx = WAIT_HIGH;
                   end
                 end
      WAIT_HIGH: if (rs) st_nx = IDLE;
      default:   st_nx = IDLE;
    endcase
  end

  // Wire order is data[1..7] then data[0]; a 3-bit idx+1 wraps 7 onto bit 0.
  assign pos = idx + 3'd1;

  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      st  <= IDLE;
      idx <= '0;
      sh  <= '0;
    end else begin
      st <= st_nx;
      if (st == START)             idx <= '0;
      else if (st == DATA && last) idx <= idx + 3'd1;
      if (st == DATA && dec)       sh[pos] <= bitv;
    end

  // A byte is only accepted when the consumer side is fully back in H_IDLE.
  always_comb begin
    hs_nx   = hs;
    load    = 1'b0;
    ovr_set = good && (hs != H_IDLE);
    case (hs)
      H_IDLE:  if (good) begin
                 hs_nx = H_REQ;
                 load  = 1'b1;
               end
      H_REQ:   if (u.ack)  hs_nx = H_DROP;
      H_DROP:  if (!u.ack) hs_nx = H_IDLE;
      default: hs_nx = H_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      hs     <= H_IDLE;
      data_q <= 8'h00;
      err_q  <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      hs    <= hs_nx;
      err_q <= ferr;
      ovr_q <= ovr_set;
      if (load) data_q <= sh;
    end

  assign u.data = data_q;
  assign u.req  = (hs == H_REQ);
  assign u.err  = err_q;
  assign u.ovr  = ovr_q;
endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at default parameters (18 clks per bit).
module tb_uart_receiver;
  logic clk = 1'b0;
  logic clr = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   err_cyc = 0, ovr_cyc = 0, req_rises = 0;
  logic req_q = 1'b0;
  logic [7:0] d0, d1;
  int   e0, o0, r0;

  uart_receiver_if u();

  uart_receiver #(.DIVIDE(2), .TICKS_PER_BIT(9), .SAMPLE_TICK(4)) dut (
    .clk (clk),
    .clr (clr),
    .u   (u)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (u.err) err_cyc++;
    if (u.ovr) ovr_cyc++;
    if (u.req && !req_q) req_rises++;
    req_q = u.req;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bitw(input logic v);
    u.rcv = v;
    cyc(18);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop1);
    bitw(1'b0);
    for (int i = 1; i < 8; i++) bitw(b[i]);
    bitw(b[0]);
    bitw(stop1);
    if (stop1) bitw(1'b1);
  endtask

  task automatic do_ack();
    int n;
    u.ack = 1'b1;
    n = 0;
    while (u.req && n < 20) begin cyc(1); n++; end
    check("ack_drop_req", 32'(u.req), 32'd0);
    u.ack = 1'b0;
    cyc(2);
  endtask

  task automatic ack_once(output logic [7:0] d);
    int n;
    n = 0;
    while (!u.req && n < 2000) begin cyc(1); n++; end
    check("b2b_req_seen", 32'(u.req), 32'd1);
    d = u.data;
    cyc(3);
    do_ack();
  endtask

  initial begin
    u.rcv = 1'b1;
    u.ack = 1'b0;
    #2 clr = 1'b0;
    #1;
    check("rst_data", 32'(u.data), 32'h00);
    check("rst_req",  32'(u.req),  32'd0);
    check("rst_err",  32'(u.err),  32'd0);
    check("rst_ovr",  32'(u.ovr),  32'd0);
    cyc(3);
    clr = 1'b1;
    cyc(10);
    check("idle_req", 32'(u.req), 32'd0);

    // A5: req up, then req drops exactly one clk after ack is seen
    send_frame(8'hA5, 1'b1);
    check("a5_req",  32'(u.req),  32'd1);
    check("a5_data", 32'(u.data), 32'hA5);
    u.ack = 1'b1;
    @(negedge clk);
    check("a5_req_hold", 32'(u.req), 32'd1);
    cyc(1);
    check("a5_req_fall", 32'(u.req), 32'd0);
    u.ack = 1'b0;
    cyc(4);

    // back-to-back 00 / FF with a prompt consumer
    o0 = ovr_cyc; r0 = req_rises;
    fork
      begin send_frame(8'h00, 1'b1); send_frame(8'hFF, 1'b1); end
      begin ack_once(d0); ack_once(d1); end
    join
    check("b2b_d0",   32'(d0), 32'h00);
    check("b2b_d1",   32'(d1), 32'hFF);
    check("b2b_ovr",  32'(ovr_cyc - o0), 32'd0);
    check("b2b_reqs", 32'(req_rises - r0), 32'd2);

    // framing error on 3C, line held low, then recovery with 11
    e0 = err_cyc; r0 = req_rises;
    send_frame(8'h3C, 1'b0);
    check("ferr_pulse", 32'(err_cyc - e0), 32'd1);
    check("ferr_req",   32'(u.req), 32'd0);
    cyc(40);
    check("ferr_hold_err", 32'(err_cyc - e0), 32'd1);
    u.rcv = 1'b1;
    cyc(20);
    send_frame(8'h11, 1'b1);
    check("rec_req",  32'(u.req),  32'd1);
    check("rec_data", 32'(u.data), 32'h11);
    check("rec_reqs", 32'(req_rises - r0), 32'd1);
    do_ack();

    // 6-clk glitch is a false start
    e0 = err_cyc; r0 = req_rises;
    u.rcv = 1'b0;
    cyc(6);
    u.rcv = 1'b1;
    cyc(60);
    check("fs_req", 32'(req_rises - r0), 32'd0);
    check("fs_err", 32'(err_cyc - e0),   32'd0);

    // overrun: 55 unacked, AA dropped
    o0 = ovr_cyc; r0 = req_rises;
    send_frame(8'h55, 1'b1);
    check("ov_req",   32'(u.req),  32'd1);
    check("ov_data0", 32'(u.data), 32'h55);
    send_frame(8'hAA, 1'b1);
    check("ov_pulse", 32'(ovr_cyc - o0), 32'd1);
    check("ov_data1", 32'(u.data), 32'h55);
    check("ov_reqhi", 32'(u.req),  32'd1);
    do_ack();
    cyc(60);
    check("ov_no_2nd_req", 32'(req_rises - r0), 32'd1);
    check("ov_req_low",    32'(u.req), 32'd0);

    // reset in the middle of data bit 4 (data still holds 55)
    bitw(1'b0);
    bitw(1'b0); bitw(1'b0); bitw(1'b0);
    u.rcv = 1'b0;
    cyc(9);
    clr = 1'b0;
    #1;
    check("rd_data", 32'(u.data), 32'h00);
    check("rd_req",  32'(u.req),  32'd0);
    check("rd_err",  32'(u.err),  32'd0);
    check("rd_ovr",  32'(u.ovr),  32'd0);
    u.rcv = 1'b1;
    cyc(3);
    clr = 1'b1;
    cyc(30);

    // reset while req is high
    send_frame(8'hC3, 1'b1);
    check("rq_req_pre",  32'(u.req),  32'd1);
    check("rq_data_pre", 32'(u.data), 32'hC3);
    #3 clr = 1'b0;
    #1;
    check("rq_req",  32'(u.req),  32'd0);
    check("rq_data", 32'(u.data), 32'h00);
    check("rq_ovr",  32'(u.ovr),  32'd0);
    cyc(3);
    clr = 1'b1;
    cyc(10);

    send_frame(8'h81, 1'b1);
    check("post_req",  32'(u.req),  32'd1);
    check("post_data", 32'(u.data), 32'h81);
    do_ack();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial receiver for the team's UART link: recovers bytes framed by our existing serial transmitter and delivers each one to a consumer over a four-phase req/ack handshake. It sits between the off-chip receive line and the byte consumer. It uses the same tick divider and ticks-per-bit convention as the transmitter, so a transmitter and receiver built with equal parameters interoperate.

## Interface
- DIVIDE, 2: clocks per tick; must be ≥1.
- TICKS_PER_BIT, 9: ticks per bit period; must be ≥3.
- SAMPLE_TICK, 4: tick index (0-based) at which a bit is sampled; must be ≥1 and < TICKS_PER_BIT-1.
- clk  in  1  system clock; all state changes on its rising edge.
- clr  in  1  reset; asynchronous, active-low.
- rcv  in  1  serial line, asynchronous to clk, idles high.
- ack  in  1  consumer acknowledge.
- data  out  8  received byte; reset 8'h00.
- req  out  1  byte-valid request; reset 0.
- err  out  1  framing-error pulse, one clk; reset 0.
- ovr  out  1  overrun pulse, one clk; reset 0.

## Operation
- Frame on wire: start (0), then data[1], data[2], …, data[7], data[0], then two stop bits (1). Each bit is TICKS_PER_BIT ticks long.
- rcv passes through a 2-flop synchronizer; all logic uses the synchronized value (rs).
- Tick generator: a divider counts 0..DIVIDE-1 and emits a one-clk tick at wrap. A tick counter tc runs 0..TICKS_PER_BIT-1. Both are held at 0 in IDLE and restart on the clk where a start edge is detected.
- Receive FSM states:
  - IDLE: rs==0 → START.
  - START: at tc==SAMPLE_TICK, rs==1 → IDLE (false start). At tc==TICKS_PER_BIT-1 → DATA with idx=0.
  - DATA: sample rs at SAMPLE_TICK into a shift position. idx 0..6 map to data[1..7]; idx 7 maps to data[0]. At the last tick, idx==7 → STOP, otherwise idx+1.
  - STOP: at SAMPLE_TICK, rs==1 → frame good, go to IDLE. rs==0 → err pulse, go to WAIT_HIGH.
  - WAIT_HIGH: rs==1 → IDLE.
- A frame is complete only at the first stop bit's sample. The second stop bit is idle margin, so the next start is detectable from that point.
- Handshake FSM:
  - H_IDLE: a good frame loads data, sets req=1, and moves to H_REQ.
  - H_REQ: ack==1 → req=0 → H_DROP.
  - H_DROP: ack==0 → H_IDLE.
- data is stable from req rise until the handshake returns to H_IDLE.
- Overrun: a good frame completing while the handshake is not in H_IDLE is discarded. data is unchanged and ovr pulses.
- A framing error never loads data and never raises req.
- Reset asserted mid-frame or mid-handshake: all FSMs, counters and outputs return to reset values immediately. After release, the line is re-acquired from IDLE.

## Timing
- Start detect: 2 clks of synchronizer latency plus 1 clk after the falling edge on rcv.
- Bit period: DIVIDE*TICKS_PER_BIT clks (18 by default).
- Sample point: SAMPLE_TICK ticks into each bit.
- req rises 1 clk after the stop-bit sample tick.
- req falls 1 clk after ack is sampled high.
- err and ovr assert 1 clk after the stop-bit sample tick, for exactly 1 clk.
- Simultaneous cases:
  - Good frame completes on the same clk the handshake enters H_IDLE: the byte is accepted.
  - Good frame completes on the clk ack drops in H_DROP: the byte is overrun.

## Configuration
- UART_RCV_GLITCH_FILTER_EN defined: each sample is the 2-of-3 majority of rs at ticks SAMPLE_TICK-1, SAMPLE_TICK and SAMPLE_TICK+1. The false-start check uses the same majority. Decision timing moves to tick SAMPLE_TICK+1, and every latency above shifts by one tick.
- Not defined: a single sample at SAMPLE_TICK.

## Test plan
- Byte 8'hA5 at default params: drive wire bits 0, 0,1,0,0,1,0,1,1, 1,1 at 18 clks each → req=1, data=8'hA5. ack high → req low next clk.
- Back-to-back frames 8'h00 then 8'hFF, with ack returned within 5 clks of each req → two handshakes, data 8'h00 then 8'hFF, ovr never asserts.
- Stop bit driven 0 on byte 8'h3C → err pulses 1 clk, req stays 0. Hold rcv low 40 clks, then release → FSM returns to IDLE; the next frame 8'h11 is received correctly.
- rcv low for 6 clks, then high → no req, no err, FSM back to IDLE.
- Receive 8'h55 without acking, then send 8'hAA → ovr pulses once, data stays 8'h55. Completing the handshake afterwards → no second req.
- Assert clr mid-data (bit 4) and mid-req → req, err, ovr and data go to 0 asynchronously. Next frame 8'h81 is received correctly.
